// File: rtl/div_hilo_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// div_hilo_sequencer_pkg
// Shared definitions for the HI/LO divide engine: the FSM state encoding, the
// fixed request-to-commit latency and the divide-by-zero quotient pattern.
// The hazard unit imports this package so it can size its stall checks.
// -----------------------------------------------------------------------------
package div_hilo_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } div_state_e;

  // Cycles beyond the WIDTH loop iterations: PREP, FIXUP, and the commit into DONE.
  localparam int DIV_LATENCY_EXTRA = 3;

  // Edge that accepts start -> cycle in which done is high and HI/LO hold the result.
  function automatic int div_latency(input int width);
    return width + DIV_LATENCY_EXTRA;
  endfunction

  // Quotient reported for a zero divisor (all ones, any width up to 64).
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_hilo_sequencer_step.sv
// -----------------------------------------------------------------------------
// div_hilo_sequencer_step
// One iteration of the restoring divider, purely combinational.
// {rem,quo} is shifted left one bit; if the shifted remainder is at least the
// divisor, the divisor is subtracted and a 1 enters the quotient LSB.
// Ports:
//   rem_i / quo_i  current partial remainder / quotient (dividend bits shift out)
//   dvs_i          divisor magnitude
//   rem_o / quo_o  values after this iteration
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic             borrow;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    rem_sh         = {rem_i, quo_i[WIDTH-1]};
    {borrow, diff} = {1'b0, rem_sh[WIDTH-1:0]} - {1'b0, dvs_i};
    // rem_sh has WIDTH+1 bits; a set top bit always exceeds the divisor, and the
    // low WIDTH bits of the difference stay exact because the result is < divisor.
    ge             = rem_sh[WIDTH] | ~borrow;
    rem_o          = ge ? diff : rem_sh[WIDTH-1:0];
    quo_o          = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_hilo_sequencer.sv
// -----------------------------------------------------------------------------
// div_hilo_sequencer
// Multi-cycle DIV/DIVU engine for the EX stage. A request is captured in IDLE,
// operand magnitudes are formed in PREP, WIDTH restoring iterations run in RUN,
// signs are restored in FIXUP and the result commits into HI (remainder) and
// LO (quotient) on entry to DONE. Also owns HI/LO for MTHI/MTLO/MFHI/MFLO.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, is_signed     divide request (IDLE only) and DIV/DIVU select
//   a, b                 dividend / divisor, captured with start
//   cancel               pipeline flush; aborts PREP/RUN/FIXUP, drops an IDLE start
//   hi_we, lo_we, wdata  MTHI / MTLO writes
//   busy                 registered, high in PREP/RUN/FIXUP
//   stall                combinational pipeline hold
//   done                 one-cycle pulse in the cycle HI/LO show the result
//   hi, lo               HI / LO registers
// -----------------------------------------------------------------------------
module div_hilo_sequencer
  import div_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return v[WIDTH-1] ? n : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic signed [WIDTH-1:0] v,
                                                input logic neg);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return neg ? n : v;
  endfunction

  div_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;

    // Moves to HI/LO first so a divide commit on the same edge overrides them.
    if (hi_we) hi_d = wdata;
    if (lo_we) lo_d = wdata;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          state_d = ST_PREP;
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
        end
      end
      ST_PREP: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
          qneg_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d  = sgn_q & a_q[WIDTH-1];
          div0_d  = (b_q == '0);
          rem_d   = '0;
          quo_d   = sgn_q ? abs_val($signed(a_q)) : a_q;
          dvs_d   = sgn_q ? abs_val($signed(b_q)) : b_q;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (div0_q) begin
            lo_d = DIV0_QUOTIENT[WIDTH-1:0];
            hi_d = a_q;
          end else begin
            lo_d = neg_if($signed(quo_q), qneg_q);
            hi_d = neg_if($signed(rem_q), rneg_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_PREP) || (state_d == ST_RUN) || (state_d == ST_FIXUP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q | ((state_q == ST_IDLE) & start & ~cancel);

endmodule

// File: tb/tb_div_hilo_sequencer.sv
module tb_div_hilo_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  div_hilo_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide in the current cycle (cycle 0) and wait for done.
  // lat = cycle index where done was seen (60 = never); stall_bad flags any
  // cycle before done where stall was low, or stall high in the done cycle.
  task automatic run_div(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic stall_bad);
    int cyc;
    stall_bad = 1'b0;
    start = 1'b1; is_signed = sgn; a = av; b = bv;
    #1;
    if (stall !== 1'b1) stall_bad = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (stall !== 1'b1) stall_bad = 1'b1;
      tick();
      cyc++;
    end
    if (done === 1'b1 && stall !== 1'b0) stall_bad = 1'b1;
    lat = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; is_signed = 0; a = '0; b = '0;
    cancel = 0; hi_we = 0; lo_we = 0; wdata = '0;
    repeat (3) tick();
    vectors++;
    if ({busy, done, stall} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctl: got %b expected 000", {busy, done, stall});
    end
    vectors++;
    if (hi !== '0 || lo !== '0) begin
      miscompares++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divu_basic();
    int lat; logic sb;
    run_div(1'b0, 32'd100, 32'd7, lat, sb);
    vectors++;
    if (lat !== 35) begin
      miscompares++; $display("FAIL divu_latency: got %0d expected 35", lat);
    end
    vectors++;
    if (sb !== 1'b0) begin
      miscompares++; $display("FAIL divu_stall: stall profile wrong, got flag %b expected 0", sb);
    end
    vectors++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      miscompares++; $display("FAIL divu_100_7: got lo=%0d hi=%0d expected 14/2", lo, hi);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL done_pulse: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_div_signed();
    logic [W-1:0] av [3] = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9};
    logic [W-1:0] bv [3] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [W-1:0] eq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    logic [W-1:0] er [3] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      int lat; logic sb;
      run_div(1'b1, av[i], bv[i], lat, sb);
      vectors++;
      if (lat !== 35 || lo !== eq[i] || hi !== er[i]) begin
        miscompares++;
        $display("FAIL div_signed_%0d: got lat=%0d lo=%h hi=%h expected 35 %h %h",
                 i, lat, lo, hi, eq[i], er[i]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    logic         sv [3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] av [3] = '{32'd5, 32'd5, 32'hFFFF_FFFB};
    for (int i = 0; i < 3; i++) begin
      int lat; logic sb;
      run_div(sv[i], av[i], 32'd0, lat, sb);
      vectors++;
      if (lat !== 35 || lo !== 32'hFFFF_FFFF || hi !== av[i]) begin
        miscompares++;
        $display("FAIL div_zero_%0d: got lat=%0d lo=%h hi=%h expected 35 ffffffff %h",
                 i, lat, lo, hi, av[i]);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    int lat; logic sb;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, sb);
    vectors++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      miscompares++; $display("FAIL div_overflow: got lo=%h hi=%h expected 80000000/0", lo, hi);
    end
    tick();
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, sb);
    vectors++;
    if (lo !== 32'd0 || hi !== 32'h8000_0000) begin
      miscompares++; $display("FAIL divu_big: got lo=%h hi=%h expected 0/80000000", lo, hi);
    end
    tick();
  endtask

  task automatic test_mt_writes();
    hi_we = 1; wdata = 32'h1111; tick(); hi_we = 0;
    lo_we = 1; wdata = 32'h2222; tick(); lo_we = 0;
    vectors++;
    if (hi !== 32'h1111 || lo !== 32'h2222) begin
      miscompares++; $display("FAIL mt_single: got hi=%h lo=%h expected 1111/2222", hi, lo);
    end
    hi_we = 1; lo_we = 1; wdata = 32'h5555; tick(); hi_we = 0; lo_we = 0;
    vectors++;
    if (hi !== 32'h5555 || lo !== 32'h5555) begin
      miscompares++; $display("FAIL mt_both: got hi=%h lo=%h expected 5555/5555", hi, lo);
    end
  endtask

  task automatic test_cancel();
    int lat; logic sb;
    // start together with cancel in IDLE: dropped
    start = 1; a = 32'd100; b = 32'd7; cancel = 1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL cancel_start_stall: got %b expected 0", stall);
    end
    tick(); start = 0; cancel = 0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL cancel_start_busy: got %b expected 0", busy);
    end
    // abort an in-flight divide in cycle 10
    start = 1; is_signed = 0; a = 32'd100; b = 32'd7;
    tick(); start = 0;
    repeat (9) tick();
    cancel = 1;
    tick(); cancel = 0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h5555 || lo !== 32'h5555) begin
      miscompares++;
      $display("FAIL cancel_run: got busy=%b done=%b hi=%h lo=%h expected 0 0 5555 5555",
               busy, done, hi, lo);
    end
    run_div(1'b0, 32'd100, 32'd7, lat, sb);
    vectors++;
    if (lat !== 35 || sb !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
      miscompares++;
      $display("FAIL cancel_restart: got lat=%0d sb=%b lo=%0d hi=%0d expected 35 0 14 2",
               lat, sb, lo, hi);
    end
    tick();
  endtask

  task automatic test_commit_priority();
    // cycle 0: start 100/7
    start = 1; is_signed = 0; a = 32'd100; b = 32'd7;
    tick(); start = 0;
    repeat (4) tick();                         // cycle 5
    lo_we = 1; wdata = 32'hBEEF;
    tick(); lo_we = 0;                         // cycle 6
    vectors++;
    if (lo !== 32'hBEEF || busy !== 1'b1) begin
      miscompares++; $display("FAIL mtlo_in_run: got lo=%h busy=%b expected beef 1", lo, busy);
    end
    repeat (14) tick();                        // cycle 20: start while busy is ignored
    start = 1; is_signed = 1; a = 32'd1; b = 32'd1;
    tick(); start = 0;                         // cycle 21
    repeat (13) tick();                        // cycle 34 (FIXUP)
    hi_we = 1; wdata = 32'hDEAD;
    tick(); hi_we = 0;                         // cycle 35
    vectors++;
    if (done !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
      miscompares++;
      $display("FAIL commit_wins: got done=%b hi=%h lo=%h expected 1 2 e", done, hi, lo);
    end
    start = 1; is_signed = 0; a = 32'd9; b = 32'd3;   // start in DONE is ignored
    tick(); start = 0;                         // cycle 36
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL start_in_done: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic sb; int seen;
    start = 1; is_signed = 0; a = 32'd100; b = 32'd7;
    tick(); start = 0;
    repeat (19) tick();                        // cycle 20
    rst = 1;
    tick(); rst = 0;
    vectors++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0", hi, lo, busy, done);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL reset_no_done: got %0d done pulses expected 0", seen);
    end
    run_div(1'b0, 32'd9, 32'd3, lat, sb);
    vectors++;
    if (lat !== 35 || lo !== 32'd3 || hi !== 32'd0) begin
      miscompares++; $display("FAIL after_reset_9_3: got lat=%0d lo=%0d hi=%0d expected 35 3 0", lat, lo, hi);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_mt_writes();
    test_cancel();
    test_commit_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
